// File: rtl/csr_prog_loader.sv
// CSR bus initiator: streams a program into instruction memory, writes the loop
// registers, starts the core, polls busy and reads back the AM prediction.
module csr_prog_loader #(
   parameter int unsigned CsrDataWidth  = 32,
   parameter int unsigned CsrAddrWidth  = 32,
   parameter int unsigned InstAddrWidth = 10
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [InstAddrWidth-1:0] num_inst_i,
   input  logic [1:0]               loop_mode_i,
   input  logic [23:0]              loop_jump_i,
   input  logic [23:0]              loop_end_i,
   input  logic [23:0]              loop_count_i,
   input  logic [CsrDataWidth-1:0]  inst_data_i,
   input  logic                     inst_valid_i,
   output logic                     inst_ready_o,
   output logic [CsrAddrWidth-1:0]  csr_req_addr_o,
   output logic [CsrDataWidth-1:0]  csr_req_data_o,
   output logic                     csr_req_write_o,
   output logic                     csr_req_valid_o,
   input  logic                     csr_req_ready_i,
   input  logic [CsrDataWidth-1:0]  csr_rsp_data_i,
   input  logic                     csr_rsp_valid_i,
   output logic                     csr_rsp_ready_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [7:0]               predict_o,
   output logic                     predict_valid_o
);

   localparam int unsigned LoopFieldWidth = 24;

   typedef enum logic [3:0] {
      S_IDLE, S_CTRL_ON, S_FETCH, S_WR_ADDR, S_WR_DATA, S_CTRL_OFF, S_LP_CTRL,
      S_LP_JUMP, S_LP_END, S_LP_CNT, S_START, S_POLL, S_RD_PRED, S_DONE
   } state_e;

   state_e                    state_q, state_d, nxt;
   logic                      wait_q, wait_d, advance;
   logic                      req_valid_q, req_valid_d, req_write_q, req_write_d;
   logic [CsrAddrWidth-1:0]   req_addr_q, req_addr_d;
   logic [CsrDataWidth-1:0]   req_data_q, req_data_d;
   logic                      rsp_ready_q, rsp_ready_d, inst_ready_q, inst_ready_d;
   logic                      busy_q, busy_d, done_q, done_d;
   logic [7:0]                predict_q, predict_d;
   logic                      pvalid_q, pvalid_d;
   logic [InstAddrWidth-1:0]  cnt_q, cnt_d, num_q, num_d, cnt_inc;
   logic [CsrDataWidth-1:0]   word_q, word_d;
   logic [1:0]                mode_q, mode_d;
   logic [LoopFieldWidth-1:0] jump_q, jump_d, lend_q, lend_d, lcnt_q, lcnt_d;
   logic                      unused_rsp_bits;

   assign unused_rsp_bits = ^csr_rsp_data_i[CsrDataWidth-1:9];
   assign cnt_inc         = cnt_q + InstAddrWidth'(1);

   // Next-state logic; each CSR state is an issue phase then a wait phase (wait_q).
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      req_valid_d  = req_valid_q;
      req_write_d  = req_write_q;
      req_addr_d   = req_addr_q;
      req_data_d   = req_data_q;
      rsp_ready_d  = rsp_ready_q;
      inst_ready_d = inst_ready_q;
      done_d       = 1'b0;
      predict_d    = predict_q;
      pvalid_d     = pvalid_q;
      cnt_d        = cnt_q;
      num_d        = num_q;
      word_d       = word_q;
      mode_d       = mode_q;
      jump_d       = jump_q;
      lend_d       = lend_q;
      lcnt_d       = lcnt_q;
      advance      = 1'b0;
      nxt          = state_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               num_d   = num_inst_i;
               mode_d  = loop_mode_i;
               jump_d  = loop_jump_i;
               lend_d  = loop_end_i;
               lcnt_d  = loop_count_i;
               cnt_d   = '0;
               nxt     = S_CTRL_ON;
               advance = 1'b1;
            end
         end
         S_FETCH: begin
            if (inst_valid_i && inst_ready_q) begin
               word_d  = inst_data_i;
               nxt     = S_WR_ADDR;
               advance = 1'b1;
            end
         end
         S_DONE: begin
            nxt     = S_IDLE;
            advance = 1'b1;
         end
         default: begin
            if (!wait_q) begin
               if (req_valid_q && csr_req_ready_i) begin
                  req_valid_d = 1'b0;
                  wait_d      = 1'b1;
                  rsp_ready_d = 1'b1;
               end
            end else if (csr_rsp_valid_i) begin
               advance = 1'b1;
               case (state_q)
                  S_CTRL_ON:  nxt = (num_q == '0) ? S_CTRL_OFF : S_FETCH;
                  S_WR_ADDR:  nxt = S_WR_DATA;
                  S_WR_DATA: begin
                     cnt_d = cnt_inc;
                     nxt   = (cnt_inc == num_q) ? S_CTRL_OFF : S_FETCH;
                  end
                  S_CTRL_OFF: nxt = S_LP_CTRL;
                  S_LP_CTRL:  nxt = S_LP_JUMP;
                  S_LP_JUMP:  nxt = S_LP_END;
                  S_LP_END:   nxt = S_LP_CNT;
                  S_LP_CNT:   nxt = S_START;
                  S_START:    nxt = S_POLL;
                  S_POLL:     nxt = csr_rsp_data_i[1] ? S_POLL : S_RD_PRED;
                  S_RD_PRED: begin
                     predict_d = csr_rsp_data_i[7:0];
                     pvalid_d  = csr_rsp_data_i[8];
                     nxt       = S_DONE;
                  end
                  default:    nxt = S_IDLE;
               endcase
            end
         end
      endcase

      // Entering a state: issue its request in the very next cycle.
      if (advance) begin
         state_d      = nxt;
         wait_d       = 1'b0;
         inst_ready_d = (nxt == S_FETCH);
         done_d       = (nxt == S_DONE);
         req_valid_d  = 1'b1;
         req_write_d  = 1'b1;
         req_addr_d   = '0;
         req_data_d   = '0;
         rsp_ready_d  = 1'b0;
         case (nxt)
            S_CTRL_ON:  begin req_addr_d = CsrAddrWidth'(3);  req_data_d = CsrDataWidth'(1); end
            S_WR_ADDR:  begin req_addr_d = CsrAddrWidth'(4);  req_data_d = CsrDataWidth'(cnt_d); end
            S_WR_DATA:  begin req_addr_d = CsrAddrWidth'(5);  req_data_d = word_d; end
            S_CTRL_OFF: begin req_addr_d = CsrAddrWidth'(3); end
            S_LP_CTRL:  begin req_addr_d = CsrAddrWidth'(9);  req_data_d = CsrDataWidth'(mode_d); end
            S_LP_JUMP:  begin req_addr_d = CsrAddrWidth'(10); req_data_d = CsrDataWidth'(jump_d); end
            S_LP_END:   begin req_addr_d = CsrAddrWidth'(11); req_data_d = CsrDataWidth'(lend_d); end
            S_LP_CNT:   begin req_addr_d = CsrAddrWidth'(12); req_data_d = CsrDataWidth'(lcnt_d); end
            S_START:    begin req_addr_d = CsrAddrWidth'(0);  req_data_d = CsrDataWidth'(1); end
            S_POLL:     begin req_addr_d = CsrAddrWidth'(0);  req_write_d = 1'b0; end
            S_RD_PRED:  begin req_addr_d = CsrAddrWidth'(2);  req_write_d = 1'b0; end
            default: begin
               req_valid_d = 1'b0;
               req_write_d = 1'b0;
               rsp_ready_d = 1'b1;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         wait_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         req_write_q  <= 1'b0;
         req_addr_q   <= '0;
         req_data_q   <= '0;
         rsp_ready_q  <= 1'b1;
         inst_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         predict_q    <= '0;
         pvalid_q     <= 1'b0;
         cnt_q        <= '0;
         num_q        <= '0;
         word_q       <= '0;
         mode_q       <= '0;
         jump_q       <= '0;
         lend_q       <= '0;
         lcnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         req_valid_q  <= req_valid_d;
         req_write_q  <= req_write_d;
         req_addr_q   <= req_addr_d;
         req_data_q   <= req_data_d;
         rsp_ready_q  <= rsp_ready_d;
         inst_ready_q <= inst_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         predict_q    <= predict_d;
         pvalid_q     <= pvalid_d;
         cnt_q        <= cnt_d;
         num_q        <= num_d;
         word_q       <= word_d;
         mode_q       <= mode_d;
         jump_q       <= jump_d;
         lend_q       <= lend_d;
         lcnt_q       <= lcnt_d;
      end
   end

   assign csr_req_valid_o = req_valid_q;
   assign csr_req_write_o = req_write_q;
   assign csr_req_addr_o  = req_addr_q;
   assign csr_req_data_o  = req_data_q;
   assign csr_rsp_ready_o = rsp_ready_q;
   assign inst_ready_o    = inst_ready_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign predict_o       = predict_q;
   assign predict_valid_o = pvalid_q;

endmodule
